terminal_scheduler: RTL

- Sequencing controller for the two service terminals (TERMINAL1, TERMINAL2) whose availability is produced by the terminal selector logic.
- Queues requests from four requesters and hands each free, enabled terminal to the next pending requester in round-robin order.
- Holds each terminal until the terminal reports completion.
- Sits between the requester front-end and the terminal selector; the selector's outputs drive EN_T1/EN_T2.

---
 rtl/terminal_scheduler.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/terminal_scheduler.sv
// Round-robin scheduler handing two service terminals to four requesters.
// Optional per-service watchdog with forced release: define TERM_TIMEOUT_EN.
module terminal_scheduler #(
  parameter int CNT_W = 8
`ifdef TERM_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [3:0]       REQ,
  input  logic             EN_T1,
  input  logic             EN_T2,
  input  logic             DONE_T1,
  input  logic             DONE_T2,
  output logic [3:0]       GNT_T1,
  output logic [3:0]       GNT_T2,
  output logic             BUSY_T1,
  output logic             BUSY_T2,
  output logic [2:0]       QUEUE_LEN,
  output logic [CNT_W-1:0] SERVED,
  output logic             TIMEOUT_FLAG
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} term_state_e;

  term_state_e      t1_state_q, t1_state_d;
  term_state_e      t2_state_q, t2_state_d;
  logic [3:0]       gnt1_q, gnt1_d;
  logic [3:0]       gnt2_q, gnt2_d;
  logic [3:0]       pend_q, pend_d;
  logic [1:0]       rr_q, rr_d;
  logic [2:0]       qlen_q, qlen_d;
  logic [CNT_W-1:0] served_q, served_d;

  logic             first_vld, second_vld;
  logic [1:0]       first_idx, second_idx, scan_idx;
  logic             grant1, grant2;
  logic [1:0]       g1_idx, g2_idx;
  logic [3:0]       gmask1, gmask2;
  logic             elig1, elig2;
  logic             inc1, inc2;
  logic             to_hit1, to_hit2;
  logic [CNT_W:0]   served_sum;

  assign elig1 = (t1_state_q == IDLE) && EN_T1;
  assign elig2 = (t2_state_q == IDLE) && EN_T2;

  // T2 takes the second pending index in search order when T1 also grants.
  always_comb begin
    first_vld  = 1'b0;
    second_vld = 1'b0;
    first_idx  = 2'd0;
    second_idx = 2'd0;
    scan_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = rr_q + 2'(k);
      if (pend_q[scan_idx]) begin
        if (!first_vld) begin
          first_vld = 1'b1;
          first_idx = scan_idx;
        end else if (!second_vld) begin
          second_vld = 1'b1;
          second_idx = scan_idx;
        end
      end
    end
    grant1 = 1'b0;
    grant2 = 1'b0;
    g1_idx = first_idx;
    g2_idx = second_idx;
    if (elig1) begin
      grant1 = first_vld;
      if (elig2) grant2 = second_vld;
    end else if (elig2) begin
      grant2 = first_vld;
      g2_idx = first_idx;
    end
  end

  assign gmask1 = grant1 ? (4'b0001 << g1_idx) : 4'b0000;
  assign gmask2 = grant2 ? (4'b0001 << g2_idx) : 4'b0000;

  always_comb begin
    t1_state_d = t1_state_q;
    gnt1_d     = gnt1_q;
    inc1       = 1'b0;
    case (t1_state_q)
      IDLE: begin
        if (grant1) begin
          t1_state_d = BUSY;
          gnt1_d     = gmask1;
        end
      end
      BUSY: begin
        if (DONE_T1) begin
          t1_state_d = IDLE;
          gnt1_d     = 4'b0000;
          inc1       = 1'b1;
        end else if (to_hit1) begin
          t1_state_d = IDLE;
          gnt1_d     = 4'b0000;
        end
      end
      default: t1_state_d = IDLE;
    endcase
  end

  always_comb begin
    t2_state_d = t2_state_q;
    gnt2_d     = gnt2_q;
    inc2       = 1'b0;
    case (t2_state_q)
      IDLE: begin
        if (grant2) begin
          t2_state_d = BUSY;
          gnt2_d     = gmask2;
        end
      end
      BUSY: begin
        if (DONE_T2) begin
          t2_state_d = IDLE;
          gnt2_d     = 4'b0000;
          inc2       = 1'b1;
        end else if (to_hit2) begin
          t2_state_d = IDLE;
          gnt2_d     = 4'b0000;
        end
      end
      default: t2_state_d = IDLE;
    endcase
  end

  // Current owners cannot re-queue; a grant clears the bit even if set this edge.
  always_comb begin
    pend_d = (pend_q | (REQ & ~(gnt1_q | gnt2_q))) & ~(gmask1 | gmask2);
    qlen_d = 3'd0;
    for (int i = 0; i < 4; i++) begin
      qlen_d = qlen_d + 3'(pend_d[i]);
    end
    rr_d = rr_q;
    if (grant2) rr_d = g2_idx + 2'd1;
    else if (grant1) rr_d = g1_idx + 2'd1;
  end

  always_comb begin
    served_sum = {1'b0, served_q} + (CNT_W+1)'(inc1) + (CNT_W+1)'(inc2);
    served_d   = served_sum[CNT_W] ? {CNT_W{1'b1}} : served_sum[CNT_W-1:0];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      t1_state_q <= IDLE;
      t2_state_q <= IDLE;
      gnt1_q     <= 4'b0000;
      gnt2_q     <= 4'b0000;
      pend_q     <= 4'b0000;
      rr_q       <= 2'd0;
      qlen_q     <= 3'd0;
      served_q   <= '0;
    end else begin
      t1_state_q <= t1_state_d;
      t2_state_q <= t2_state_d;
      gnt1_q     <= gnt1_d;
      gnt2_q     <= gnt2_d;
      pend_q     <= pend_d;
      rr_q       <= rr_d;
      qlen_q     <= qlen_d;
      served_q   <= served_d;
    end
  end

`ifdef TERM_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic [TMR_W-1:0] tmr1_q, tmr1_d;
  logic [TMR_W-1:0] tmr2_q, tmr2_d;
  logic             flag_q, flag_d;

  assign to_hit1 = (t1_state_q == BUSY) && (tmr1_q == TMR_W'(TIMEOUT - 1));
  assign to_hit2 = (t2_state_q == BUSY) && (tmr2_q == TMR_W'(TIMEOUT - 1));

  // Timers restart on every grant and only run across consecutive BUSY cycles.
  always_comb begin
    tmr1_d = '0;
    tmr2_d = '0;
    if (t1_state_q == BUSY && t1_state_d == BUSY) tmr1_d = tmr1_q + 1'b1;
    if (t2_state_q == BUSY && t2_state_d == BUSY) tmr2_d = tmr2_q + 1'b1;
    flag_d = flag_q | (to_hit1 & ~DONE_T1) | (to_hit2 & ~DONE_T2);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tmr1_q <= '0;
      tmr2_q <= '0;
      flag_q <= 1'b0;
    end else begin
      tmr1_q <= tmr1_d;
      tmr2_q <= tmr2_d;
      flag_q <= flag_d;
    end
  end

  assign TIMEOUT_FLAG = flag_q;
`else
  assign to_hit1      = 1'b0;
  assign to_hit2      = 1'b0;
  assign TIMEOUT_FLAG = 1'b0;
`endif

  assign GNT_T1    = gnt1_q;
  assign GNT_T2    = gnt2_q;
  assign BUSY_T1   = (t1_state_q == BUSY);
  assign BUSY_T2   = (t2_state_q == BUSY);
  assign QUEUE_LEN = qlen_q;
  assign SERVED    = served_q;

endmodule
